// File: rtl/hc_sb.sv
// ---------------------------------------------------------------------------
// hc_sb -- hazard-control scoreboard for an in-order pipeline.
//
// Tracks the destination register of every in-flight single-cycle/load
// instruction for NSTAGE post-decode stages, and one multi-cycle (MDU)
// operation with a down-counter. From that state and the D-stage decode
// inputs it produces, combinationally, the D-stage stall request and the
// per-source forwarding selects.
//
// Build option: define HC_FWD_EN to enable result forwarding. Without it the
// forwarding selects are tied to 0 and any in-flight producer of a source
// register stalls D until it leaves the tracked window.
//
// Ports:
//   clk, reset_n        clock (rising edge), synchronous active-low reset
//   rs1/rs2_addr_D      D-stage source register addresses
//   rs1/rs2_used_D      source actually read by the D instruction
//   rd_addr_D, rd_wen_D D-stage destination and its write enable
//   is_load_D, is_mdu_D D instruction class
//   valid_D             D holds a real instruction
//   flush               kill every tracked in-flight instruction
//   stall_D             hold D and insert a bubble into E
//   fwd_sel_rs1/rs2     0 = register file, k+1 = result bus of entry k
//   mdu_busy            MDU counter non-zero
//   mdu_wb              single-cycle pulse when the MDU result is written
//   mdu_rd              destination of the in-flight MDU operation
// ---------------------------------------------------------------------------
module hc_sb #(
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int MDU_LAT    = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [4:0]                    rs1_addr_D,
    input  logic [4:0]                    rs2_addr_D,
    input  logic                          rs1_used_D,
    input  logic                          rs2_used_D,
    input  logic [4:0]                    rd_addr_D,
    input  logic                          rd_wen_D,
    input  logic                          is_load_D,
    input  logic                          is_mdu_D,
    input  logic                          valid_D,
    input  logic                          flush,
    output logic                          stall_D,
    output logic [$clog2(NSTAGE+1)-1:0]   fwd_sel_rs1,
    output logic [$clog2(NSTAGE+1)-1:0]   fwd_sel_rs2,
    output logic                          mdu_busy,
    output logic                          mdu_wb,
    output logic [4:0]                    mdu_rd
);

    localparam int SW = $clog2(NSTAGE + 1);
    localparam int CW = $clog2(MDU_LAT + 1);

    // Tracking entries: index 0 is the E stage, NSTAGE-1 the last stage
    // before register-file write.
    logic [NSTAGE-1:0]      vld_q, vld_d;
    logic [NSTAGE-1:0][4:0] rd_q, rd_d;
    logic [NSTAGE-1:0]      ld_q, ld_d;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [4:0]             mdu_rd_q, mdu_rd_d;

    // Youngest-match result per source: {hit, is_load of match, k+1}
    logic [SW+1:0]          m1_s, m2_s;
    logic                   haz1_s, haz2_s, mdu_haz_s, mdu_busy_s;
    logic                   issue_s, mdu_issue_s;

    // Scan from oldest to youngest so the lowest matching index wins.
    function automatic logic [SW+1:0] youngest(
        input logic                   used,
        input logic [4:0]             addr,
        input logic [NSTAGE-1:0]      vld,
        input logic [NSTAGE-1:0][4:0] rd,
        input logic [NSTAGE-1:0]      ld
    );
        logic          hit;
        logic          ld_hit;
        logic [SW-1:0] sel;
        hit    = 1'b0;
        ld_hit = 1'b0;
        sel    = {SW{1'b0}};
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (used && (addr != 5'd0) && vld[k] && (rd[k] == addr)) begin
                hit    = 1'b1;
                ld_hit = ld[k];
                sel    = SW'(k + 1);
            end else begin
                hit    = hit;
            end
        end
        return {hit, ld_hit, sel};
    endfunction

`ifdef HC_FWD_EN
    logic rdy1_s, rdy2_s;
`else
    // Load class and match position are irrelevant without forwarding.
    logic unused_match_s;
    assign unused_match_s = ^{m1_s[SW:0], m2_s[SW:0]};
`endif

    // Hazard detection, forwarding selection and MDU status outputs.
    always_comb begin
        m1_s       = youngest(rs1_used_D, rs1_addr_D, vld_q, rd_q, ld_q);
        m2_s       = youngest(rs2_used_D, rs2_addr_D, vld_q, rd_q, ld_q);
        mdu_busy_s = (cnt_q != {CW{1'b0}});
        // Structural (second MDU op), RAW and WAW against the MDU destination.
        mdu_haz_s  = mdu_busy_s && (is_mdu_D
                   || (rs1_used_D && (mdu_rd_q != 5'd0) && (rs1_addr_D == mdu_rd_q))
                   || (rs2_used_D && (mdu_rd_q != 5'd0) && (rs2_addr_D == mdu_rd_q))
                   || (rd_wen_D   && (mdu_rd_q != 5'd0) && (rd_addr_D  == mdu_rd_q)));
`ifdef HC_FWD_EN
        // A load result only exists from LOAD_STAGE on (sel = k+1 > LOAD_STAGE).
        rdy1_s      = !m1_s[SW] || (m1_s[SW-1:0] > SW'(LOAD_STAGE));
        rdy2_s      = !m2_s[SW] || (m2_s[SW-1:0] > SW'(LOAD_STAGE));
        fwd_sel_rs1 = (m1_s[SW+1] && rdy1_s) ? m1_s[SW-1:0] : {SW{1'b0}};
        fwd_sel_rs2 = (m2_s[SW+1] && rdy2_s) ? m2_s[SW-1:0] : {SW{1'b0}};
        haz1_s      = m1_s[SW+1] && !rdy1_s;
        haz2_s      = m2_s[SW+1] && !rdy2_s;
`else
        fwd_sel_rs1 = {SW{1'b0}};
        fwd_sel_rs2 = {SW{1'b0}};
        haz1_s      = m1_s[SW+1];
        haz2_s      = m2_s[SW+1];
`endif
        stall_D  = valid_D && (haz1_s || haz2_s || mdu_haz_s);
        mdu_busy = mdu_busy_s;
        // Flush or reset abandons the op, so no write-back pulse.
        mdu_wb   = reset_n && !flush && (cnt_q == CW'(1));
        mdu_rd   = mdu_rd_q;
    end

    // Next-state: entry shift, issue into entry 0, MDU counter and target.
    always_comb begin
        issue_s     = valid_D && !stall_D && rd_wen_D && (rd_addr_D != 5'd0)
                    && !is_mdu_D && !flush;
        mdu_issue_s = valid_D && is_mdu_D && !stall_D && !flush;

        vld_d    = {NSTAGE{1'b0}};
        rd_d     = rd_q;
        ld_d     = ld_q;
        vld_d[0] = issue_s;
        rd_d[0]  = rd_addr_D;
        ld_d[0]  = is_load_D;
        for (int i = 1; i < NSTAGE; i++) begin
            vld_d[i] = vld_q[i-1] && !flush;
            rd_d[i]  = rd_q[i-1];
            ld_d[i]  = ld_q[i-1];
        end

        if (flush) begin
            cnt_d = {CW{1'b0}};
        end else if (mdu_issue_s) begin
            cnt_d = CW'(MDU_LAT);
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (mdu_issue_s) begin
            mdu_rd_d = rd_wen_D ? rd_addr_D : 5'd0;
        end else begin
            mdu_rd_d = mdu_rd_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q    <= {NSTAGE{1'b0}};
            rd_q     <= {(NSTAGE*5){1'b0}};
            ld_q     <= {NSTAGE{1'b0}};
            cnt_q    <= {CW{1'b0}};
            mdu_rd_q <= 5'd0;
        end else begin
            vld_q    <= vld_d;
            rd_q     <= rd_d;
            ld_q     <= ld_d;
            cnt_q    <= cnt_d;
            mdu_rd_q <= mdu_rd_d;
        end
    end

endmodule

// File: tb/tb_hc_sb.sv
module tb_hc_sb;

    localparam int NSTAGE     = 3;
    localparam int LOAD_STAGE = 1;
    localparam int MDU_LAT    = 8;
    localparam int SW         = $clog2(NSTAGE + 1);
`ifdef HC_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n, flush, valid_D;
    logic [4:0]    rs1_addr_D, rs2_addr_D, rd_addr_D;
    logic          rs1_used_D, rs2_used_D, rd_wen_D, is_load_D, is_mdu_D;
    logic          stall_D, mdu_busy, mdu_wb;
    logic [SW-1:0] fwd_sel_rs1, fwd_sel_rs2;
    logic [4:0]    mdu_rd;

    hc_sb #(.NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE), .MDU_LAT(MDU_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .rd_addr_D(rd_addr_D), .rd_wen_D(rd_wen_D),
        .is_load_D(is_load_D), .is_mdu_D(is_mdu_D),
        .valid_D(valid_D), .flush(flush),
        .stall_D(stall_D), .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .mdu_rd(mdu_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rn, fl, vd;
        logic [4:0] r1;
        logic       u1;
        logic [4:0] r2;
        logic       u2;
        logic [4:0] rd;
        logic       we, ld, md;
        logic       e_st;
        logic [SW-1:0] e_f1, e_f2;
        logic       e_bz, e_wb;
        logic [4:0] e_rd;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: history of issued instructions by cycle index.
    bit         h_iss [0:4095];
    logic [4:0] h_rd  [0:4095];
    bit         h_ld  [0:4095];
    int         cyc     = 0;
    int         kill_c  = 0;
    bit         mdu_act = 1'b0;
    int         mdu_c   = 0;
    logic [4:0] m_rd    = 5'd0;

    function automatic vec_t mk(input int rn, fl, vd, r1, u1, r2, u2, rd, we, ld, md,
                                input int st, f1, f2, bz, wb, erd);
        vec_t v;
        v.rn = 1'(rn); v.fl = 1'(fl); v.vd = 1'(vd);
        v.r1 = 5'(r1); v.u1 = 1'(u1); v.r2 = 5'(r2); v.u2 = 1'(u2);
        v.rd = 5'(rd); v.we = 1'(we); v.ld = 1'(ld); v.md = 1'(md);
        v.e_st = 1'(st); v.e_f1 = SW'(f1); v.e_f2 = SW'(f2);
        v.e_bz = 1'(bz); v.e_wb = 1'(wb); v.e_rd = 5'(erd);
        return v;
    endfunction

    // Youngest in-flight producer of addr: age a means entry a-1.
    function automatic void src_eval(input logic used, input logic [4:0] addr,
                                     output logic hz, output logic [SW-1:0] sel);
        bit found;
        hz = 1'b0; sel = {SW{1'b0}}; found = 1'b0;
        if (used && addr != 5'd0) begin
            for (int age = 1; age <= NSTAGE; age++) begin
                int c;
                c = cyc - age;
                if (!found && c >= 0 && c >= kill_c && h_iss[c] && h_rd[c] == addr) begin
                    found = 1'b1;
                    if (FWD && (!h_ld[c] || (age - 1) >= LOAD_STAGE)) sel = SW'(age);
                    else hz = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_eval(input vec_t v, output logic st,
                                       output logic [SW-1:0] f1, output logic [SW-1:0] f2,
                                       output logic bz, output logic wb, output logic [4:0] mr);
        logic hz1, hz2, mhz;
        src_eval(v.u1, v.r1, hz1, f1);
        src_eval(v.u2, v.r2, hz2, f2);
        bz  = mdu_act && (cyc > mdu_c) && (cyc <= mdu_c + MDU_LAT);
        wb  = bz && (cyc == mdu_c + MDU_LAT) && v.rn && !v.fl;
        mhz = bz && (v.md || (v.u1 && m_rd != 5'd0 && v.r1 == m_rd)
                          || (v.u2 && m_rd != 5'd0 && v.r2 == m_rd)
                          || (v.we && m_rd != 5'd0 && v.rd == m_rd));
        st  = v.vd && (hz1 || hz2 || mhz);
        mr  = m_rd;
    endfunction

    task automatic model_commit(input vec_t v, input logic st);
        h_iss[cyc] = 1'b0;
        if (!v.rn) begin
            kill_c = cyc + 1; mdu_act = 1'b0; m_rd = 5'd0;
        end else if (v.fl) begin
            kill_c = cyc + 1; mdu_act = 1'b0;
        end else begin
            if (v.vd && !st && v.we && v.rd != 5'd0 && !v.md) begin
                h_iss[cyc] = 1'b1; h_rd[cyc] = v.rd; h_ld[cyc] = v.ld;
            end
            if (v.vd && v.md && !st) begin
                mdu_act = 1'b1; mdu_c = cyc; m_rd = v.we ? v.rd : 5'd0;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string ph, input int id, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] %s: got %0d expected %0d", ph, id, nm, act, exp);
        end
    endtask

    // mode 0: drive only, 1: check against table, 2: check against model
    task automatic run_cycle(input vec_t v, input int mode, input int id);
        logic st, bz, wb;
        logic [SW-1:0] f1, f2;
        logic [4:0] mr;
        reset_n = v.rn; flush = v.fl; valid_D = v.vd;
        rs1_addr_D = v.r1; rs1_used_D = v.u1; rs2_addr_D = v.r2; rs2_used_D = v.u2;
        rd_addr_D = v.rd; rd_wen_D = v.we; is_load_D = v.ld; is_mdu_D = v.md;
        @(negedge clk);
        model_eval(v, st, f1, f2, bz, wb, mr);
        if (mode == 1) begin
            chk("vec", id, "stall_D", 32'(stall_D), 32'(v.e_st));
            chk("vec", id, "fwd_sel_rs1", 32'(fwd_sel_rs1), 32'(v.e_f1));
            chk("vec", id, "fwd_sel_rs2", 32'(fwd_sel_rs2), 32'(v.e_f2));
            chk("vec", id, "mdu_busy", 32'(mdu_busy), 32'(v.e_bz));
            chk("vec", id, "mdu_wb", 32'(mdu_wb), 32'(v.e_wb));
            chk("vec", id, "mdu_rd", 32'(mdu_rd), 32'(v.e_rd));
        end else if (mode == 2) begin
            chk("rnd", id, "stall_D", 32'(stall_D), 32'(st));
            chk("rnd", id, "fwd_sel_rs1", 32'(fwd_sel_rs1), 32'(f1));
            chk("rnd", id, "fwd_sel_rs2", 32'(fwd_sel_rs2), 32'(f2));
            chk("rnd", id, "mdu_busy", 32'(mdu_busy), 32'(bz));
            chk("rnd", id, "mdu_wb", 32'(mdu_wb), 32'(wb));
            chk("rnd", id, "mdu_rd", 32'(mdu_rd), 32'(mr));
        end
        @(posedge clk);
        model_commit(v, st);
        #1;
    endtask

    initial begin
        int nf;
        vec_t v;
        nf = FWD ? 0 : 1;
        for (int i = 0; i < 4096; i++) h_iss[i] = 1'b0;

        // Reset / single-cycle forwarding
        tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 5,1,0,0, 0,0,0,0,0,0));
        for (int a = 1; a <= 3; a++)
            tbl.push_back(mk(1,0,1, 5,1,0,0, 0,0,0,0, nf, FWD ? a : 0, 0,0,0,0));
        tbl.push_back(mk(1,0,1, 5,1,0,0, 0,0,0,0, 0,0,0,0,0,0));
        // Load-use
        tbl.push_back(mk(1,0,1, 0,0,0,0, 7,1,1,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,7,1, 0,0,0,0, 1,0,0,0,0,0));
        for (int a = 2; a <= 3; a++)
            tbl.push_back(mk(1,0,1, 0,0,7,1, 0,0,0,0, nf, 0, FWD ? a : 0, 0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,7,1, 0,0,0,0, 0,0,0,0,0,0));
        // Youngest match wins; x0 never matches
        tbl.push_back(mk(1,0,1, 0,0,0,0, 3,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 8,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 3,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 3,1,0,1, 0,0,0,0, nf, FWD ? 1 : 0, 0,0,0,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 0,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,1,0,1, 0,0,0,0, 0,0,0,0,0,0));
        // DIV x9: busy 8 cycles, wb on the 8th, reader stalled throughout
        tbl.push_back(mk(1,0,1, 0,0,0,0, 9,1,0,1, 0,0,0,0,0,0));
        for (int c = 8; c >= 1; c--)
            tbl.push_back(mk(1,0,1, 9,1,0,0, 0,0,0,0, 1,0,0,1, (c == 1) ? 1 : 0, 9));
        tbl.push_back(mk(1,0,1, 9,1,0,0, 0,0,0,0, 0,0,0,0,0,9));
        // Flush at MDU count 4 with live entries; flush coincident with issue
        tbl.push_back(mk(1,0,1, 0,0,0,0, 10,1,0,1, 0,0,0,0,0,9));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 11,1,0,0, 0,0,0,1,0,10));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 12,1,0,0, 0,0,0,1,0,10));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 13,1,0,0, 0,0,0,1,0,10));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 10,1,0,0, 1,0,0,1,0,10));
        tbl.push_back(mk(1,1,1, 0,0,0,0, 14,1,0,0, 0,0,0,1,0,10));
        tbl.push_back(mk(1,0,1, 13,1,14,1, 0,0,0,0, 0,0,0,0,0,10));
        // Flush exactly on the write-back cycle suppresses mdu_wb
        tbl.push_back(mk(1,0,1, 0,0,0,0, 2,1,0,1, 0,0,0,0,0,10));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1,0,2));
        tbl.push_back(mk(1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,1,0,2));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,2));
        // Reset mid-count, and reset on the write-back cycle
        tbl.push_back(mk(1,0,1, 0,0,0,0, 6,1,0,1, 0,0,0,0,0,2));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1,0,6));
        tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1,0,6));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 6,1,0,1, 0,0,0,0,0,0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1,0,6));
        tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1,0,6));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));

        // Initial reset, not checked (state is unknown before the first edge)
        v = mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0);
        #1;
        run_cycle(v, 0, 0);
        run_cycle(v, 0, 0);

        foreach (tbl[i]) run_cycle(tbl[i], 1, i);

        for (int i = 0; i < 1500; i++) begin
            v = mk(($urandom_range(0, 63) != 0) ? 1 : 0,
                   ($urandom_range(0, 31) == 0) ? 1 : 0,
                   ($urandom_range(0, 3) != 0) ? 1 : 0,
                   $urandom_range(0, 6), $urandom_range(0, 1),
                   $urandom_range(0, 6), $urandom_range(0, 1),
                   $urandom_range(0, 6), $urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   ($urandom_range(0, 9) == 0) ? 1 : 0,
                   0,0,0,0,0,0);
            run_cycle(v, 2, i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
